dump_sequencer: RTL and testbench

//  Sequences the receiver dump (coil energy discharge) phase of the NMR echo train.
//  On a start pulse it latches the phase config and drives timer_start to the external
//  12-bit dump_timer counter, watching its count to time each phase.
//  It produces cfg_cycles dump pulses on dump_on, each cfg_on_len cycles high, separated
//  by cfg_off_len low cycles, then pulses done. It sits between the top-level pulse-

---
 rtl/dump_sequencer_pkg.sv | 37 +++
 rtl/dump_len_cfg.sv | 31 +++
 rtl/dump_sequencer.sv | 110 +++++++++++
 tb/tb_dump_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dump_sequencer_pkg.sv
// Shared types for the receiver dump sequencer: one-hot phase encoding,
// the minimum off length, and the per-state registered output set.
package dump_sequencer_pkg;

  // Shortest legal low gap: CLR_A + at least one OFF cycle + CLR_B.
  localparam int unsigned MIN_OFF_LEN = 3;

  // One-hot phase encoding, shared with the top-level pulse-sequence FSM.
  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_ON    = 6'b000010,
    ST_CLR_A = 6'b000100,
    ST_OFF   = 6'b001000,
    ST_CLR_B = 6'b010000,
    ST_FIN   = 6'b100000
  } dump_state_e;

  // Outputs that are a pure function of the phase being entered.
  typedef struct packed {
    logic timer_start;
    logic dump_on;
    logic busy;
    logic done;
  } dump_out_t;

  // Output set for a phase; registered by the caller on entry to that phase.
  function automatic dump_out_t state_outputs(dump_state_e st);
    dump_out_t o;
    o             = '0;
    o.timer_start = (st == ST_ON) || (st == ST_OFF);
    o.dump_on     = (st == ST_ON);
    o.busy        = (st != ST_IDLE);
    o.done        = (st == ST_FIN);
    return o;
  endfunction

endpackage

// File: rtl/dump_len_cfg.sv
// Dump phase length latch: captures on/off lengths on an accepted start,
// clamps them to their legal minimum and holds the terminal compare values
// on_last = on_len-1 and off_last = off_len-3 for the sequencer.
module dump_len_cfg
  import dump_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] cfg_on_len,
  input  logic [CNT_W-1:0] cfg_off_len,
  output logic [CNT_W-1:0] on_last,
  output logic [CNT_W-1:0] off_last
);

  // Clamped terminal counts are computed at load time so the compare path
  // in the sequencer sees plain registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      on_last  <= '0;
      off_last <= '0;
    end else if (load) begin
      on_last  <= (cfg_on_len == '0) ? '0 : cfg_on_len - CNT_W'(1);
      off_last <= (cfg_off_len < CNT_W'(MIN_OFF_LEN)) ? '0
                : cfg_off_len - CNT_W'(MIN_OFF_LEN);
    end
  end

endmodule

// File: rtl/dump_sequencer.sv
// Receiver dump sequencer: issues cfg_cycles dump pulses of on_len cycles
// separated by off_len low cycles, timed by the external dump_timer, then
// pulses done. Dropping state_start while busy aborts back to idle.
module dump_sequencer
  import dump_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 12,
  parameter int unsigned NUM_W = 8
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             state_start,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_on_len,
  input  logic [CNT_W-1:0] cfg_off_len,
  input  logic [NUM_W-1:0] cfg_cycles,
  input  logic [CNT_W-1:0] count,
  output logic             timer_start,
  output logic             dump_on,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [NUM_W-1:0] cycles_left
);

  dump_state_e      state_q;
  dump_state_e      state_d;
  logic [NUM_W-1:0] cycles_left_q;
  logic [NUM_W-1:0] cycles_left_d;
  logic             load_cfg;
  logic             abort_d;
  logic [CNT_W-1:0] on_last;
  logic [CNT_W-1:0] off_last;
  dump_out_t        out_q;
  logic             aborted_q;

  dump_len_cfg #(
    .CNT_W (CNT_W)
  ) u_len_cfg (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .load        (load_cfg),
    .cfg_on_len  (cfg_on_len),
    .cfg_off_len (cfg_off_len),
    .on_last     (on_last),
    .off_last    (off_last)
  );

  // Next-phase and pulse-count logic; abort overrides every other transition.
  // count is compared directly in ON/OFF: the timer is held clear during the
  // IDLE/CLR_x cycle before each phase, so it reads 0 on the first cycle.
  always_comb begin
    state_d       = state_q;
    cycles_left_d = cycles_left_q;
    load_cfg      = 1'b0;
    abort_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && state_start) begin
          load_cfg      = 1'b1;
          cycles_left_d = cfg_cycles;
          state_d       = (cfg_cycles == '0) ? ST_FIN : ST_ON;
        end
      end
      ST_ON: begin
        if (count == on_last) begin
          cycles_left_d = cycles_left_q - NUM_W'(1);
          state_d       = (cycles_left_q == NUM_W'(1)) ? ST_FIN : ST_CLR_A;
        end
      end
      ST_CLR_A: state_d = ST_OFF;
      ST_OFF: begin
        if (count == off_last) state_d = ST_CLR_B;
      end
      ST_CLR_B: state_d = ST_ON;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // FIN already carries done and returns to IDLE anyway, so it never aborts.
    if ((state_q != ST_IDLE) && !state_start) begin
      state_d       = ST_IDLE;
      cycles_left_d = cycles_left_q;
      load_cfg      = 1'b0;
      abort_d       = (state_q != ST_FIN);
    end
  end

  // Phase register, pulse counter and outputs registered from the phase being entered.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cycles_left_q <= '0;
      out_q         <= '0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycles_left_q <= cycles_left_d;
      out_q         <= state_outputs(state_d);
      aborted_q     <= abort_d;
    end
  end

  assign timer_start = out_q.timer_start;
  assign dump_on     = out_q.dump_on;
  assign busy        = out_q.busy;
  assign done        = out_q.done;
  assign aborted     = aborted_q;
  assign cycles_left = cycles_left_q;

endmodule

// File: tb/tb_dump_sequencer.sv
// Self-checking bench for dump_sequencer. A behavioural model expands each
// accepted start into the expected per-cycle output waveform (queue of
// cycles) and compares every cycle; an external dump_timer model drives count.
module tb_dump_sequencer;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        state_start = 1'b1;
  logic        start = 1'b0;
  logic [11:0] cfg_on_len = '0;
  logic [11:0] cfg_off_len = '0;
  logic [7:0]  cfg_cycles = '0;
  logic [11:0] count;
  logic        timer_start;
  logic        dump_on;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [7:0]  cycles_left;

  dump_sequencer #(
    .CNT_W (12),
    .NUM_W (8)
  ) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .state_start (state_start),
    .start       (start),
    .cfg_on_len  (cfg_on_len),
    .cfg_off_len (cfg_off_len),
    .cfg_cycles  (cfg_cycles),
    .count       (count),
    .timer_start (timer_start),
    .dump_on     (dump_on),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .cycles_left (cycles_left)
  );

  always #5 clk_sys = ~clk_sys;

  // External dump_timer: clear while disabled, count up while enabled.
  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= timer_start ? count + 12'd1 : 12'd0;
  end

  typedef struct packed {
    logic       ts;
    logic       on;
    logic       bsy;
    logic       dn;
    logic       ab;
    logic [7:0] cl;
  } exp_t;

  exp_t        q[$];
  exp_t        exp_cur;
  logic [7:0]  last_cl = '0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic ts, input logic on, input logic bsy,
                              input logic dn, input logic ab, input logic [7:0] cl);
    exp_t e;
    e.ts = ts; e.on = on; e.bsy = bsy; e.dn = dn; e.ab = ab; e.cl = cl;
    return e;
  endfunction

  // Expand a start into its full waveform: pulses, gaps, then the done cycle.
  task automatic build(input int unsigned on, input int unsigned off, input int unsigned cyc);
    int unsigned onl;
    int unsigned offl;
    onl  = (on == 0) ? 1 : on;
    offl = (off < 3) ? 3 : off;
    q.delete();
    if (cyc == 0) q.push_back(mk(0, 0, 1, 1, 0, 8'd0));
    for (int unsigned k = 0; k < cyc; k++) begin
      logic [7:0] cl;
      cl = 8'(cyc - k);
      for (int unsigned j = 0; j < onl; j++) q.push_back(mk(1, 1, 1, 0, 0, cl));
      if (k == cyc - 1) begin
        q.push_back(mk(0, 0, 1, 1, 0, 8'd0));
      end else begin
        q.push_back(mk(0, 0, 1, 0, 0, cl - 8'd1));
        for (int unsigned j = 0; j < offl - 2; j++) q.push_back(mk(1, 0, 1, 0, 0, cl - 8'd1));
        q.push_back(mk(0, 0, 1, 0, 0, cl - 8'd1));
      end
    end
  endtask

  task automatic compare_all();
    check("timer_start", 32'(timer_start), 32'(exp_cur.ts));
    check("dump_on",     32'(dump_on),     32'(exp_cur.on));
    check("busy",        32'(busy),        32'(exp_cur.bsy));
    check("done",        32'(done),        32'(exp_cur.dn));
    check("aborted",     32'(aborted),     32'(exp_cur.ab));
    check("cycles_left", 32'(cycles_left), 32'(exp_cur.cl));
  endtask

  // One clock: advance the model with the inputs the DUT sampled, then compare.
  task automatic step();
    @(posedge clk_sys);
    if (q.size() != 0) begin
      last_cl = q[0].cl;
      if (!state_start && !q[0].dn) begin
        q.delete();
        exp_cur = mk(0, 0, 0, 0, 1, last_cl);
      end else begin
        q.delete(0);
        exp_cur = (q.size() != 0) ? q[0] : mk(0, 0, 0, 0, 0, last_cl);
      end
    end else if (start && state_start) begin
      build(cfg_on_len, cfg_off_len, cfg_cycles);
      exp_cur = q[0];
    end else begin
      exp_cur = mk(0, 0, 0, 0, 0, last_cl);
    end
    #1;
    compare_all();
  endtask

  // Start a sequence and run it out, scrambling inputs that must be ignored.
  task automatic run_seq(input int unsigned on, input int unsigned off,
                         input int unsigned cyc, input int abort_at);
    cfg_on_len  = 12'(on);
    cfg_off_len = 12'(off);
    cfg_cycles  = 8'(cyc);
    start       = 1'b1;
    state_start = 1'b1;
    step();
    for (int i = 0; i < 4000 && q.size() != 0; i++) begin
      state_start = (i == abort_at) ? 1'b0 : 1'b1;
      start       = ($urandom_range(0, 5) == 0);
      cfg_on_len  = 12'($urandom);
      cfg_off_len = 12'($urandom);
      cfg_cycles  = 8'($urandom);
      step();
    end
    start       = 1'b0;
    state_start = 1'b1;
    step();
    check("idle_after_seq", 32'(busy), 32'd0);
  endtask

  initial begin
    exp_cur = mk(0, 0, 0, 0, 0, 8'd0);
    #1;
    compare_all();
    #12 rst_n = 1'b1;
    step();

    // Basic 4H/5L pattern, three pulses.
    run_seq(4, 5, 3, -1);
    // Zero pulses: straight to done.
    run_seq(0, 0, 0, -1);
    // Clamped lengths.
    run_seq(0, 1, 2, -1);

    // Abort in the first gap's OFF phase: cycles_left holds 4.
    cfg_on_len = 12'd10; cfg_off_len = 12'd10; cfg_cycles = 8'd5;
    start = 1'b1; state_start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 13; i++) step();
    state_start = 1'b0;
    step();
    check("abort_pulse", 32'(aborted), 32'd1);
    check("abort_cycles_left", 32'(cycles_left), 32'd4);
    state_start = 1'b1;
    step();
    check("abort_no_done", 32'(done), 32'd0);

    // Start with state_start low is ignored.
    cfg_on_len = 12'd3; cfg_off_len = 12'd4; cfg_cycles = 8'd2;
    start = 1'b1; state_start = 1'b0;
    step();
    check("start_gated", 32'(busy), 32'd0);
    start = 1'b0; state_start = 1'b1;
    step();

    // Asynchronous reset during ON.
    cfg_on_len = 12'd8; cfg_off_len = 12'd4; cfg_cycles = 8'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    #1 rst_n = 1'b0;
    #1;
    q.delete();
    last_cl = '0;
    exp_cur = mk(0, 0, 0, 0, 0, 8'd0);
    compare_all();
    #1 rst_n = 1'b1;
    step();
    run_seq(2, 3, 2, -1);

    // Randomized sequences with occasional aborts and gated starts.
    for (int n = 0; n < 40; n++) begin
      int ab;
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1;
      if ($urandom_range(0, 5) == 0) begin
        start = 1'b1; state_start = 1'b0;
        step();
        start = 1'b0; state_start = 1'b1;
      end
      run_seq($urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 4), ab);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
